gb_cpu_alu16_seq: RTL and testbench

//   Sequences 16-bit adds through the 8-bit gb_cpu_alu: low byte with ADD, then high byte with ADC.

---
 rtl/gb_cpu_alu16_seq_if.sv | 61 ++++++
 rtl/gb_cpu_alu16_seq.sv | 182 ++++++++++++++++++
 tb/tb_gb_cpu_alu16_seq.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gb_cpu_alu16_seq_if.sv
// Bus bundle for gb_cpu_alu16_seq.
//
// It carries two groups of signals:
//   - the request side: start/op/operands/flags_i going in, and busy/done/result/flags_o coming out.
//   - the 8-bit ALU side: alu_instr/alu_flags_i going out to gb_cpu_alu, and alu_out/alu_flags_o coming back.
//
// Modports:
//   slave  : the sequencer itself.
//   master : everything around it, meaning the requester plus the 8-bit ALU.
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and op!=2'b11.
// Once taken, the request inputs may change freely.
// done is a one-cycle pulse. While done is high, result and flags_o are valid.
// They then hold their values until the next request is taken.
interface gb_cpu_alu16_seq_if;

  // SM83 flag nibble, ordered {Z,N,H,C} (Z is bit 3).
  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } alu_flags_t;

  // Instruction word presented to gb_cpu_alu.
  // Opcode encodings: 0=NOP, 1=ADD, 2=ADC.
  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
  } alu_instruction_t;

  logic             start;
  logic [1:0]       op;
  logic [15:0]      operand_a;
  logic [15:0]      operand_b;
  alu_flags_t       flags_i;
  alu_instruction_t alu_instr;
  alu_flags_t       alu_flags_i;
  logic [7:0]       alu_out;
  alu_flags_t       alu_flags_o;
  logic             busy;
  logic             done;
  logic [15:0]      result;
  alu_flags_t       flags_o;

  modport master (
    output start, op, operand_a, operand_b, flags_i,
    output alu_out, alu_flags_o,
    input  alu_instr, alu_flags_i,
    input  busy, done, result, flags_o
  );

  modport slave (
    input  start, op, operand_a, operand_b, flags_i,
    input  alu_out, alu_flags_o,
    output alu_instr, alu_flags_i,
    output busy, done, result, flags_o
  );

endinterface

// File: rtl/gb_cpu_alu16_seq.sv
// gb_cpu_alu16_seq: 16-bit add sequencer built on the 8-bit gb_cpu_alu.
//
// The low byte is added with ADD, then the high byte with ADC.
// This one block serves ADD HL,rr / ADD SP,e8 / LD HL,SP+e8 and JR e8 target computation.
//
// Ports:
//   clk       : rising-edge clock.
//   reset     : synchronous, active-high reset. It aborts any operation in flight.
//   bus       : gb_cpu_alu16_seq_if.slave (request/result signals plus the ALU drive/return).
//   state_dbg : current FSM state (0=IDLE, 1=LOW, 2=HIGH).
//
// op encoding:
//   00 ADD16  : HL + rr
//   01 ADD_E8 : SP + e8
//   10 REL_E8 : PC + e8
//   11        : reserved, never accepted
module gb_cpu_alu16_seq (
  input  logic                      clk,
  input  logic                      reset,
  gb_cpu_alu16_seq_if.slave         bus,
  output logic [1:0]                state_dbg
);

  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_ADD = 4'd1;
  localparam logic [3:0] OPC_ADC = 4'd2;

  localparam logic [1:0] OP_ADD16  = 2'b00;
  localparam logic [1:0] OP_ADD_E8 = 2'b01;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  fl_q, fl_d;          // latched F register {Z,N,H,C}
  logic        c_lo_q, c_lo_d;
  logic        h_lo_q, h_lo_d;
  logic [3:0]  instr_opc_q, instr_opc_d;
  logic [7:0]  instr_a_q, instr_a_d;
  logic [7:0]  instr_b_q, instr_b_d;
  logic        alu_cin_q, alu_cin_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_o_q, flags_o_d;
  logic [3:0]  flags_hi;

  // Final flags, chosen at the HIGH step.
  // The ALU's per-byte Z output is never used here.
  always_comb begin
    flags_hi = fl_q;
    case (op_q)
      OP_ADD16:  flags_hi = {fl_q[3], 1'b0, bus.alu_flags_o.h, bus.alu_flags_o.c};
      // For ADD_E8, the flags come from the low-byte add only (bit-3/bit-7 carries).
      OP_ADD_E8: flags_hi = {2'b00, h_lo_q, c_lo_q};
      default:   flags_hi = fl_q;
    endcase
  end

  // The ALU drive is registered.
  // Each state therefore loads the instruction for the step that follows it.
  // This way the ALU sees ADD for the whole LOW cycle and ADC for the whole HIGH cycle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    fl_d        = fl_q;
    c_lo_d      = c_lo_q;
    h_lo_d      = h_lo_q;
    instr_opc_d = instr_opc_q;
    instr_a_d   = instr_a_q;
    instr_b_d   = instr_b_q;
    alu_cin_d   = alu_cin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    result_d    = result_q;
    flags_o_d   = flags_o_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && (bus.op != OP_RSVD)) begin
          op_d        = bus.op;
          a_d         = bus.operand_a;
          b_d         = bus.operand_b;
          fl_d        = bus.flags_i;
          busy_d      = 1'b1;
          instr_opc_d = OPC_ADD;
          instr_a_d   = bus.operand_a[7:0];
          instr_b_d   = bus.operand_b[7:0];
          alu_cin_d   = 1'b0;
          state_d     = S_LOW;
        end
      end

      S_LOW: begin
        result_d[7:0] = bus.alu_out;
        c_lo_d        = bus.alu_flags_o.c;
        h_lo_d        = bus.alu_flags_o.h;
        instr_opc_d   = OPC_ADC;
        instr_a_d     = a_q[15:8];
        // For the e8 forms, the high byte of the offset is the sign extension of e8.
        instr_b_d     = (op_q == OP_ADD16) ? b_q[15:8] : {8{b_q[7]}};
        alu_cin_d     = bus.alu_flags_o.c;
        state_d       = S_HIGH;
      end

      S_HIGH: begin
        result_d[15:8] = bus.alu_out;
        flags_o_d      = flags_hi;
        done_d         = 1'b1;
        busy_d         = 1'b0;
        instr_opc_d    = OPC_NOP;
        instr_a_d      = 8'h00;
        instr_b_d      = 8'h00;
        alu_cin_d      = 1'b0;
        state_d        = S_IDLE;
      end

      default: begin
        busy_d      = 1'b0;
        instr_opc_d = OPC_NOP;
        instr_a_d   = 8'h00;
        instr_b_d   = 8'h00;
        alu_cin_d   = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= 2'b00;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      fl_q        <= 4'b0000;
      c_lo_q      <= 1'b0;
      h_lo_q      <= 1'b0;
      instr_opc_q <= OPC_NOP;
      instr_a_q   <= 8'h00;
      instr_b_q   <= 8'h00;
      alu_cin_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= 16'h0000;
      flags_o_q   <= 4'b0000;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fl_q        <= fl_d;
      c_lo_q      <= c_lo_d;
      h_lo_q      <= h_lo_d;
      instr_opc_q <= instr_opc_d;
      instr_a_q   <= instr_a_d;
      instr_b_q   <= instr_b_d;
      alu_cin_q   <= alu_cin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      flags_o_q   <= flags_o_d;
    end
  end

  assign bus.alu_instr   = {instr_opc_q, instr_a_q, instr_b_q};
  assign bus.alu_flags_i = {3'b000, alu_cin_q};
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.flags_o     = flags_o_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_gb_cpu_alu16_seq.sv
module tb_gb_cpu_alu16_seq;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;
  int         total;
  int         bad;
  logic [19:0] exp_q[$];   // {flags[3:0], result[15:0]}

  gb_cpu_alu16_seq_if bus ();

  gb_cpu_alu16_seq dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- 8-bit ALU stand-in (opcodes 0=NOP 1=ADD 2=ADC) ----------------
  int alu_cin;
  int alu_sum;
  int alu_nib;
  always_comb begin
    alu_cin         = 0;
    alu_sum         = 0;
    alu_nib         = 0;
    bus.alu_out     = 8'h00;
    bus.alu_flags_o = 4'b0000;
    if (bus.alu_instr.opcode == 4'd1 || bus.alu_instr.opcode == 4'd2) begin
      alu_cin = (bus.alu_instr.opcode == 4'd2) ? int'(bus.alu_flags_i.c) : 0;
      alu_sum = int'(bus.alu_instr.operand_a) + int'(bus.alu_instr.operand_b) + alu_cin;
      alu_nib = int'(bus.alu_instr.operand_a[3:0]) + int'(bus.alu_instr.operand_b[3:0]) + alu_cin;
      bus.alu_out       = alu_sum[7:0];
      bus.alu_flags_o.z = (alu_sum[7:0] == 8'h00);
      bus.alu_flags_o.n = 1'b0;
      bus.alu_flags_o.h = (alu_nib > 15);
      bus.alu_flags_o.c = (alu_sum > 255);
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [19:0] ref_model(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic [3:0] f);
    int av, bv, off, sum;
    logic h, c;
    logic [3:0] fl;
    logic [15:0] r;
    av = int'(a);
    bv = int'(b);
    if (op == 2'd0) begin
      off = bv;
    end else begin
      off = bv & 'hFF;
      if (off > 127) off = off - 256;
    end
    sum = (av + off) & 'hFFFF;
    r   = sum[15:0];
    fl  = f;
    if (op == 2'd0) begin
      h  = ((av & 'hFFF) + (bv & 'hFFF)) > 'hFFF;
      c  = (av + bv) > 'hFFFF;
      fl = {f[3], 1'b0, h, c};
    end else if (op == 2'd1) begin
      h  = ((av & 'hF) + (bv & 'hF)) > 'hF;
      c  = ((av & 'hFF) + (bv & 'hFF)) > 'hFF;
      fl = {2'b00, h, c};
    end
    return {fl, r};
  endfunction

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clk);
    reset = 1'b0;
  endtask

  // The task is entered on a negedge and returns on the negedge where done is high.
  // A following call therefore drives start in the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] f);
    logic [19:0] e;
    logic        cin_exp;
    cin_exp = ((int'(a) & 'hFF) + (int'(b) & 'hFF)) > 'hFF;
    exp_q.push_back(ref_model(op, a, b, f));
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.flags_i   = f;
    @(negedge clk);
    bus.start     = 1'b0;
    bus.op        = 2'($urandom_range(0, 3));
    bus.operand_a = 16'($urandom);
    bus.operand_b = 16'($urandom);
    bus.flags_i   = 4'($urandom);
    check("low_busy", 32'(bus.busy), 32'd1);
    check("low_opc", 32'(bus.alu_instr.opcode), 32'd1);
    check("low_a", 32'(bus.alu_instr.operand_a), 32'(a[7:0]));
    check("low_b", 32'(bus.alu_instr.operand_b), 32'(b[7:0]));
    @(negedge clk);
    check("high_opc", 32'(bus.alu_instr.opcode), 32'd2);
    check("high_a", 32'(bus.alu_instr.operand_a), 32'(a[15:8]));
    check("high_cin", 32'(bus.alu_flags_i), 32'(cin_exp));
    check("high_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    check("done", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd0);
    check("result", 32'(bus.result), 32'(e[15:0]));
    check("flags", 32'(bus.flags_o), 32'(e[19:16]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    total = 0;
    bad   = 0;
    bus.start     = 1'b0;
    bus.op        = 2'b00;
    bus.operand_a = 16'h0000;
    bus.operand_b = 16'h0000;
    bus.flags_i   = 4'b0000;

    // Reset state.
    do_reset(2);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_result", 32'(bus.result), 32'h0);
    check("rst_flags", 32'(bus.flags_o), 32'h0);
    check("rst_opc", 32'(bus.alu_instr.opcode), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Directed cases. Each case starts in the done cycle of the one before it.
    run_op(2'd0, 16'h0FFF, 16'h0001, 4'b1000);
    check("add16_a_res", 32'(bus.result), 32'h1000);
    check("add16_a_fl", 32'(bus.flags_o), 32'b1010);
    run_op(2'd0, 16'hFFFF, 16'h0001, 4'b0000);
    check("add16_wrap_res", 32'(bus.result), 32'h0000);
    check("add16_wrap_fl", 32'(bus.flags_o), 32'b0011);
    run_op(2'd1, 16'hFFF8, 16'h0008, 4'b1111);
    check("adde8_a_res", 32'(bus.result), 32'h0000);
    check("adde8_a_fl", 32'(bus.flags_o), 32'b0011);
    run_op(2'd1, 16'h1000, 16'h00FF, 4'b1111);
    check("adde8_b_res", 32'(bus.result), 32'h0FFF);
    check("adde8_b_fl", 32'(bus.flags_o), 32'b0000);
    run_op(2'd2, 16'h0150, 16'h0080, 4'b1011);
    check("rel_res", 32'(bus.result), 32'h00D0);
    check("rel_fl", 32'(bus.flags_o), 32'b1011);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);

    // A start held high during LOW must be ignored.
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 16'h1234; bus.operand_b = 16'h1111;
    bus.flags_i = 4'b0000;
    @(negedge clk);
    bus.op = 2'd0; bus.operand_a = 16'hFFFF; bus.operand_b = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("ign_done", 32'(bus.done), 32'd1);
    check("ign_res", 32'(bus.result), 32'h2345);
    @(negedge clk);
    check("ign_done2", 32'(bus.done), 32'd0);
    check("ign_busy", 32'(bus.busy), 32'd0);
    check("ign_state", 32'(state_dbg), 32'd0);

    // Reset during HIGH: the op is aborted with no done pulse, and outputs are cleared.
    bus.start = 1'b1; bus.op = 2'd0; bus.operand_a = 16'h4321; bus.operand_b = 16'h0101;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    check("abort_in_high", 32'(state_dbg), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_res", 32'(bus.result), 32'h0);
    check("abort_fl", 32'(bus.flags_o), 32'h0);
    @(negedge clk);
    check("abort_done2", 32'(bus.done), 32'd0);

    // The reserved op is never accepted.
    bus.start = 1'b1; bus.op = 2'b11;
    @(negedge clk);
    check("rsvd_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    check("rsvd_busy2", 32'(bus.busy), 32'd0);
    check("rsvd_done", 32'(bus.done), 32'd0);

    // Randomized back-to-back traffic.
    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), 4'($urandom));
    end
    bus.start = 1'b0;
    @(negedge clk);
    check("final_done", 32'(bus.done), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
